i2cs_fifo_target: RTL and testbench
===================================

# i2cs_fifo_target

Parametrised I2C target (slave) engine for the I2C peripheral subsystem. Supports 7-bit addressing with optional general-call response, and configurable input filtering. Write bytes stream into an RX FIFO and read bytes are drawn from a TX FIFO, both of depth FIFO_DEPTH. Unlike the single-register peripheral interface, it handles multi-byte bursts, back-pressure by NACK, and underflow/overflow reporting, so an APB register front-end or uDMA channel can sit directly on its FIFO ports.

## Interface
- FIFO_DEPTH, 8: entries per FIFO; power of two, 2..256; CW = $clog2(FIFO_DEPTH)+1
- DEBOUNCE_LEN, 20: cycles a synchronised SCL/SDA level must be stable before the filtered value updates (1..255)
- SDA_HOLD, 8: cycles after filtered SCL falls before i2c_sda_oe_o may change (1..255)
- apb_pclk_i in 1: single clock; all logic on rising edge
- apb_presetn_i in 1: asynchronous, active-low reset
- i2c_scl_i in 1: bus clock, asynchronous
- i2c_sda_i in 1: bus data, asynchronous
- i2c_sda_oe_o out 1: 1 = pull SDA low (pad drives 0); reset 0
- enable_i in 1: 0 forces IDLE and releases SDA; FIFO contents kept
- dev_addr_i in 7: target address
- gcall_en_i in 1: also respond to address 0x00 (write only)
- rx_data_o out 8: RX FIFO head; reset 0x00
- rx_valid_o out 1: RX non-empty; reset 0
- rx_ready_i in 1: pop when rx_valid_o & rx_ready_i
- tx_data_i in 8: byte to queue
- tx_valid_i in 1: push when tx_valid_i & tx_ready_o
- tx_ready_o out 1: TX not full; reset 1
- rx_count_o / tx_count_o out CW: occupancy; reset 0
- busy_o out 1: addressed transaction in progress; reset 0
- start_o, stop_o, rx_ovf_o, tx_unf_o out 1: one-cycle event pulses; reset 0

## Operation
- Input path: 2-FF synchroniser, then per-line debounce counter; filtered value changes only after DEBOUNCE_LEN consecutive equal samples differing from current filtered value. Filtered values reset to 1.
- START: filtered SDA 1->0 while SCL=1; STOP: SDA 0->1 while SCL=1. START (incl. repeated) from any state -> ADDR, pulse start_o. STOP from any state -> IDLE, pulse stop_o, busy_o=0.
- Bits sampled on filtered SCL rising edge, MSB first; SDA driven only in SCL-low phase.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: 8 bits shifted. Match = addr[7:1]==dev_addr_i, or gcall_en_i & addr==0x00 & R/W=0. Match -> ADDR_ACK (drive 0 for 9th clock), busy_o=1; otherwise -> IGNORE (no drive).
- R/W=0: ADDR_ACK -> WR_DATA. On 8th bit: RX not full -> push, ACK, WR_ACK -> WR_DATA. RX full -> byte dropped, rx_ovf_o pulse, NACK (released), -> IGNORE.
- R/W=1: on the SCL falling edge that ends ADDR_ACK (or a master-ACKed RD_ACK), load shift register: TX non-empty -> pop; empty -> load 0xFF, pulse tx_unf_o. RD_DATA drives oe = ~bit. After 8th bit release SDA; RD_ACK samples master: ACK (0) -> load next, RD_DATA; NACK -> IGNORE.
- IGNORE: no drive until START/STOP.
- FIFOs: circular, pointers wrap at FIFO_DEPTH; simultaneous push and pop in one cycle allowed at any occupancy (full: pop frees, push accepted the same cycle only for user-side TX push when tx_ready_o was high); count unchanged on simultaneous push+pop.
- enable_i=0: FSM to IDLE next cycle, oe=0, busy_o=0; no events except FIFO activity.

## Timing
- Input latency: 2 sync + DEBOUNCE_LEN cycles from pad to filtered edge.
- oe update SDA_HOLD cycles after filtered SCL falling edge (ACK assert, data bit, release); never during SCL high.
- RX push occurs the cycle after the 8th filtered SCL rise; rx_valid_o high one cycle later.
- TX pop and tx_ready_o/tx_count_o update one cycle after load; rx_data_o is registered FIFO head, valid while rx_valid_o.
- Event pulses exactly one cycle, in the cycle after detection.
- Reset asserted mid-transfer: all state cleared immediately, SDA released, FIFOs emptied.

## Test plan
- dev_addr 0x2A, write 0x54 then 0x11 0x22 0x33, STOP -> ACK all 4 bytes; rx_count 3; rx_data pops 0x11,0x22,0x33; start_o and stop_o one pulse each.
- FIFO_DEPTH 8, write 10 data bytes -> bytes 1-8 ACKed, 9th NACKed, rx_ovf_o one pulse, 10th not ACKed (IGNORE), rx_count 8.
- TX queued 0xA5,0x5A; read 0x55, master ACK, ACK, NACK -> SDA shows 0xA5,0x5A,0xFF; tx_unf_o one pulse; tx_count 0.
- Address 0x2B while dev_addr 0x2A -> no ACK, busy_o 0, FIFOs unchanged; gcall_en 1 and addr 0x00 write -> ACKed.
- Write reg then repeated START read -> second start_o pulse, transaction switches direction without STOP.
- SCL glitch shorter than DEBOUNCE_LEN during write; enable_i drop mid-byte; apb_presetn_i low mid-read -> glitch ignored; disable releases SDA and returns IDLE; reset clears counts to 0 and oe to 0.

Source files
------------

// File: rtl/i2cs_fifo_target.sv
`default_nettype none
// ============================================================================
// Module   : i2cs_fifo_target
// Brief    : I2C 7-bit target engine with filtered inputs and RX/TX FIFOs
// Revision : 1.0
// ============================================================================
module i2cs_fifo_target #(
  parameter int FIFO_DEPTH   = 8,
  parameter int DEBOUNCE_LEN = 20,
  parameter int SDA_HOLD     = 8,
  localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          apb_pclk_i,
  input  logic          apb_presetn_i,
  input  logic          i2c_scl_i,
  input  logic          i2c_sda_i,
  output logic          i2c_sda_oe_o,
  input  logic          enable_i,
  input  logic [6:0]    dev_addr_i,
  input  logic          gcall_en_i,
  output logic [7:0]    rx_data_o,
  output logic          rx_valid_o,
  input  logic          rx_ready_i,
  input  logic [7:0]    tx_data_i,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  output logic [CW-1:0] rx_count_o,
  output logic [CW-1:0] tx_count_o,
  output logic          busy_o,
  output logic          start_o,
  output logic          stop_o,
  output logic          rx_ovf_o,
  output logic          tx_unf_o
);
  localparam int            c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = 1;
  localparam logic [CW-1:0] c_full     = CW'(FIFO_DEPTH);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_addr     = 3'd1;
  localparam logic [2:0] c_st_addr_ack = 3'd2;
  localparam logic [2:0] c_st_wr_data  = 3'd3;
  localparam logic [2:0] c_st_wr_ack   = 3'd4;
  localparam logic [2:0] c_st_rd_data  = 3'd5;
  localparam logic [2:0] c_st_rd_ack   = 3'd6;
  localparam logic [2:0] c_st_ignore   = 3'd7;

  logic [1:0] w_pad, w_filt;
  assign w_pad = {i2c_sda_i, i2c_scl_i};

  // Per line: 2-FF synchroniser then a stability counter; idles high.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_filt
    logic [1:0] r_sync;
    logic [7:0] r_cnt;
    logic       r_val;
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
      if (!apb_presetn_i) begin
        r_sync <= 2'b11;
        r_cnt  <= '0;
        r_val  <= 1'b1;
      end else begin
        r_sync <= {r_sync[0], w_pad[gi]};
        if (r_sync[1] == r_val) begin
          r_cnt <= '0;
        end else if (r_cnt == 8'(DEBOUNCE_LEN - 1)) begin
          r_val <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
    assign w_filt[gi] = r_val;
  end

  logic w_scl, w_sda, r_scl_d, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl      = w_filt[0];
  assign w_sda      = w_filt[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;

  logic [2:0]      r_state, w_next;
  logic [6:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_ack_clk, r_rw;
  logic [7:0]      w_in_byte, w_load_byte;
  logic            w_match;
  logic            w_rx_push, w_rx_ovf, w_rd_load, w_oe_fall, w_busy;
  logic [7:0]      r_rx_mem [FIFO_DEPTH];
  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]   r_rx_cnt, r_tx_cnt;
  logic            w_rx_full, w_rx_pop, w_tx_empty, w_tx_push, w_tx_pop;

  assign w_in_byte   = {r_shift, w_sda};
  assign w_match     = (w_in_byte[7:1] == dev_addr_i) | (gcall_en_i & (w_in_byte == 8'h00));
  assign w_rx_full   = (r_rx_cnt == c_full);
  assign w_rx_pop    = (r_rx_cnt != '0) & rx_ready_i;
  assign w_tx_empty  = (r_tx_cnt == '0);
  assign w_tx_push   = tx_valid_i & tx_ready_o;
  assign w_tx_pop    = w_rd_load & ~w_tx_empty;
  assign w_load_byte = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rptr];

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) r_state <= c_st_idle;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable_i) begin
      w_next = c_st_idle;
    end else if (w_start) begin
      w_next = c_st_addr;
    end else if (w_stop) begin
      w_next = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:     w_next = c_st_idle;
        c_st_addr:     if (w_scl_rise && r_bit_cnt == 3'd7)
                         w_next = w_match ? c_st_addr_ack : c_st_ignore;
        c_st_addr_ack: if (w_scl_fall && r_ack_clk)
                         w_next = r_rw ? c_st_rd_data : c_st_wr_data;
        c_st_wr_data:  if (w_scl_rise && r_bit_cnt == 3'd7)
                         w_next = w_rx_full ? c_st_ignore : c_st_wr_ack;
        c_st_wr_ack:   if (w_scl_fall && r_ack_clk) w_next = c_st_wr_data;
        c_st_rd_data:  if (w_scl_rise && r_bit_cnt == 3'd7) w_next = c_st_rd_ack;
        c_st_rd_ack: begin
          // A master NACK ends the read; an ACK reloads on the next fall.
          if (w_scl_rise && !r_ack_clk && w_sda) w_next = c_st_ignore;
          else if (w_scl_fall && r_ack_clk)      w_next = c_st_rd_data;
        end
        c_st_ignore:   w_next = c_st_ignore;
        default:       w_next = c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_rx_push = 1'b0;
    w_rx_ovf  = 1'b0;
    w_rd_load = 1'b0;
    w_oe_fall = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      c_st_addr_ack: begin
        w_busy = 1'b1;
        if (r_ack_clk) begin
          w_rd_load = r_rw & w_scl_fall;
          w_oe_fall = r_rw & ~w_load_byte[7];
        end else begin
          w_oe_fall = 1'b1;
        end
      end
      c_st_wr_data: begin
        w_busy = 1'b1;
        if (w_scl_rise && r_bit_cnt == 3'd7) begin
          w_rx_push = ~w_rx_full;
          w_rx_ovf  = w_rx_full;
        end
      end
      c_st_wr_ack: begin
        w_busy    = 1'b1;
        w_oe_fall = ~r_ack_clk;
      end
      c_st_rd_data: begin
        w_busy    = 1'b1;
        w_oe_fall = ~r_shift[6];
      end
      c_st_rd_ack: begin
        w_busy = 1'b1;
        if (r_ack_clk) begin
          w_rd_load = w_scl_fall;
          w_oe_fall = ~w_load_byte[7];
        end
      end
      default: w_busy = 1'b0;
    endcase
    if (!enable_i || w_start || w_stop) begin
      w_rx_push = 1'b0;
      w_rx_ovf  = 1'b0;
      w_rd_load = 1'b0;
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ack_clk <= 1'b0;
      r_rw      <= 1'b0;
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      if (w_next != r_state) begin
        r_bit_cnt <= '0;
        r_ack_clk <= 1'b0;
      end else if (w_scl_rise) begin
        if (r_state == c_st_addr || r_state == c_st_wr_data || r_state == c_st_rd_data)
          r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_state == c_st_addr_ack || r_state == c_st_wr_ack || r_state == c_st_rd_ack)
          r_ack_clk <= 1'b1;
      end
      // Bit 7 of a read byte goes straight to the pad, so only 7 bits are kept.
      if (w_rd_load)
        r_shift <= w_load_byte[6:0];
      else if (w_scl_rise && (r_state == c_st_addr || r_state == c_st_wr_data))
        r_shift <= {r_shift[5:0], w_sda};
      else if (w_scl_fall && r_state == c_st_rd_data)
        r_shift <= {r_shift[5:0], 1'b0};
      if (r_state == c_st_addr && w_scl_rise && r_bit_cnt == 3'd7)
        r_rw <= w_sda;
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= w_in_byte;
        r_rx_wptr           <= r_rx_wptr + c_ptr_one;
      end
      if (w_rx_pop) r_rx_rptr <= r_rx_rptr + c_ptr_one;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= tx_data_i;
        r_tx_wptr           <= r_tx_wptr + c_ptr_one;
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + c_ptr_one;
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  // SDA changes only a hold time after SCL falls; bus conditions release at once.
  logic       r_sda_oe, r_oe_pend, r_oe_next;
  logic [7:0] r_hold_cnt;
  logic       r_start, r_stop, r_rx_ovf, r_tx_unf;
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      r_sda_oe   <= 1'b0;
      r_oe_pend  <= 1'b0;
      r_oe_next  <= 1'b0;
      r_hold_cnt <= '0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_rx_ovf   <= 1'b0;
      r_tx_unf   <= 1'b0;
    end else begin
      r_start  <= w_start & enable_i;
      r_stop   <= w_stop & enable_i;
      r_rx_ovf <= w_rx_ovf;
      r_tx_unf <= w_rd_load & w_tx_empty;
      if (!enable_i || w_start || w_stop) begin
        r_sda_oe  <= 1'b0;
        r_oe_pend <= 1'b0;
      end else if (w_scl_fall) begin
        r_oe_pend  <= 1'b1;
        r_oe_next  <= w_oe_fall;
        r_hold_cnt <= 8'(SDA_HOLD - 1);
      end else if (r_oe_pend) begin
        if (r_hold_cnt == '0) begin
          r_sda_oe  <= r_oe_next;
          r_oe_pend <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - 8'd1;
        end
      end
    end
  end

  assign i2c_sda_oe_o = r_sda_oe;
  assign rx_data_o    = r_rx_mem[r_rx_rptr];
  assign rx_valid_o   = (r_rx_cnt != '0);
  assign tx_ready_o   = (r_tx_cnt != c_full);
  assign rx_count_o   = r_rx_cnt;
  assign tx_count_o   = r_tx_cnt;
  assign busy_o       = w_busy;
  assign start_o      = r_start;
  assign stop_o       = r_stop;
  assign rx_ovf_o     = r_rx_ovf;
  assign tx_unf_o     = r_tx_unf;
endmodule
`default_nettype wire

// File: tb/tb_i2cs_fifo_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2cs_fifo_target
// Brief    : Bus-master driven scoreboard bench for i2cs_fifo_target
// Revision : 1.0
// ============================================================================
module tb_i2cs_fifo_target;
  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int HOLD  = 2;
  localparam int Q     = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe;
  wire  sda_line = sda_m & ~sda_oe;

  logic          enable = 1'b1, gcall_en = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [6:0]    dev_addr = 7'h2A;
  logic [7:0]    tx_data = 8'h00, rx_data;
  logic          rx_valid, tx_ready, busy, start_p, stop_p, ovf_p, unf_p;
  logic [CW-1:0] rx_count, tx_count;

  i2cs_fifo_target #(.FIFO_DEPTH(DEPTH), .DEBOUNCE_LEN(DB), .SDA_HOLD(HOLD)) dut (
    .apb_pclk_i(clk), .apb_presetn_i(rst_n), .i2c_scl_i(scl_m), .i2c_sda_i(sda_line),
    .i2c_sda_oe_o(sda_oe), .enable_i(enable), .dev_addr_i(dev_addr), .gcall_en_i(gcall_en),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_count_o(rx_count), .tx_count_o(tx_count), .busy_o(busy),
    .start_o(start_p), .stop_o(stop_p), .rx_ovf_o(ovf_p), .tx_unf_o(unf_p)
  );

  typedef struct { string name; int val; } item_t;
  item_t exp_q[$];
  item_t obs_q[$];
  int checks = 0, errors = 0;
  int n_ev[4] = '{0, 0, 0, 0};
  int base_ev[4];
  logic [3:0] p_ev = 4'b0;
  item_t mo, me;

  // Monitor: RX pops, event pulse widths, and scoreboard comparison.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = {unf_p, ovf_p, stop_p, start_p};
    if (rx_valid && rx_ready) obs_q.push_back('{"rx_data", int'(rx_data)});
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) begin
        n_ev[i]++;
        checks++;
        if (p_ev[i]) begin
          errors++;
          $display("FAIL pulse_width[%0d]: got high 2+ cycles, need 1", i);
        end
      end
    end
    p_ev = ev;
    while (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: got %0d, nothing expected", mo.name, mo.val);
      end else begin
        me = exp_q.pop_front();
        if (me.name != mo.name || me.val != mo.val) begin
          errors++;
          $display("FAIL %s: got %s=%0d, need %0d", me.name, mo.name, mo.val, me.val);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap(input string name, input int act, input int expv);
    exp_q.push_back('{name, expv});
    obs_q.push_back('{name, act});
  endtask

  task automatic mark();
    for (int i = 0; i < 4; i++) base_ev[i] = n_ev[i];
  endtask

  task automatic ev_chk(input string name, input int idx, input int expv);
    snap(name, n_ev[idx] - base_ev[idx], expv);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;  tick(Q);
    scl_m = 1'b1; tick(Q);
    r = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic glitch_scl();
    scl_m = 1'b1; tick(2);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic wr(input logic [7:0] b, input int exp_ack, input int glitch_at = -1);
    logic r;
    exp_q.push_back('{"ack", exp_ack});
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_at) glitch_scl();
      clock_bit(b[i], r);
    end
    clock_bit(1'b1, r);
    obs_q.push_back('{"ack", int'(!r)});
  endtask

  task automatic rd(input logic [7:0] expb, input logic mack);
    logic r;
    logic [7:0] d;
    exp_q.push_back('{"rd_data", int'(expb)});
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~mack, r);
    obs_q.push_back('{"rd_data", int'(d)});
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tick();
    tx_valid = 1'b0;
  endtask

  task automatic exp_rx(input logic [7:0] b);
    exp_q.push_back('{"rx_data", int'(b)});
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick();
    for (int i = 0; i < 2 * DEPTH + 4 && rx_valid; i++) tick();
    rx_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    logic r;
    tick(5);
    rst_n = 1'b1;
    tick(3);
    snap("rst_rx_count", int'(rx_count), 0);
    snap("rst_tx_count", int'(tx_count), 0);
    snap("rst_tx_ready", int'(tx_ready), 1);
    snap("rst_rx_valid", int'(rx_valid), 0);
    snap("rst_rx_data",  int'(rx_data), 0);
    snap("rst_oe",       int'(sda_oe), 0);
    snap("rst_busy",     int'(busy), 0);

    // Basic write burst
    mark();
    bus_start();
    wr(8'h54, 1);
    snap("busy_in_write", int'(busy), 1);
    wr(8'h11, 1); wr(8'h22, 1); wr(8'h33, 1);
    bus_stop();
    tick(4);
    snap("wr_rx_count", int'(rx_count), 3);
    snap("wr_busy_after_stop", int'(busy), 0);
    ev_chk("wr_start_pulses", 0, 1);
    ev_chk("wr_stop_pulses", 1, 1);
    exp_rx(8'h11); exp_rx(8'h22); exp_rx(8'h33);
    drain();
    snap("wr_rx_count_drained", int'(rx_count), 0);

    // RX overflow
    mark();
    bus_start();
    wr(8'h54, 1);
    for (int i = 1; i <= 10; i++) wr(8'(i), (i <= DEPTH) ? 1 : 0);
    bus_stop();
    tick(4);
    snap("ovf_rx_count", int'(rx_count), 8);
    ev_chk("ovf_pulses", 2, 1);
    for (int i = 1; i <= DEPTH; i++) exp_rx(8'(i));
    drain();

    // Read with TX underflow
    mark();
    tx_push(8'hA5); tx_push(8'h5A);
    snap("rd_tx_count_loaded", int'(tx_count), 2);
    bus_start();
    wr(8'h55, 1);
    rd(8'hA5, 1'b1);
    rd(8'h5A, 1'b1);
    rd(8'hFF, 1'b0);
    bus_stop();
    tick(4);
    ev_chk("unf_pulses", 3, 1);
    snap("rd_tx_count", int'(tx_count), 0);

    // Address mismatch, then general call
    bus_start();
    wr(8'h56, 0);
    snap("nomatch_busy", int'(busy), 0);
    wr(8'h77, 0);
    bus_stop();
    tick(4);
    snap("nomatch_rx_count", int'(rx_count), 0);
    snap("nomatch_tx_count", int'(tx_count), 0);
    gcall_en = 1'b1;
    bus_start();
    wr(8'h00, 1);
    wr(8'h99, 1);
    bus_stop();
    gcall_en = 1'b0;
    tick(4);
    snap("gcall_rx_count", int'(rx_count), 1);
    exp_rx(8'h99);
    drain();

    // Write then repeated-START read
    mark();
    tx_push(8'hC3);
    bus_start();
    wr(8'h54, 1);
    wr(8'h10, 1);
    bus_start();
    wr(8'h55, 1);
    rd(8'hC3, 1'b0);
    bus_stop();
    tick(4);
    ev_chk("rs_start_pulses", 0, 2);
    ev_chk("rs_stop_pulses", 1, 1);
    ev_chk("rs_unf_pulses", 3, 0);
    snap("rs_rx_count", int'(rx_count), 1);
    exp_rx(8'h10);
    drain();

    // Short SCL glitch inside a data byte
    bus_start();
    wr(8'h54, 1);
    wr(8'h3C, 1, 3);
    bus_stop();
    tick(4);
    snap("glitch_rx_count", int'(rx_count), 1);
    exp_rx(8'h3C);
    drain();

    // Disable while the target is holding ACK
    bus_start();
    wr(8'h54, 1);
    for (int i = 7; i >= 0; i--) clock_bit(8'h0F >> i, r);
    snap("ack_driven", int'(sda_oe), 1);
    enable = 1'b0;
    tick(2);
    snap("dis_oe", int'(sda_oe), 0);
    snap("dis_busy", int'(busy), 0);
    enable = 1'b1;
    exp_q.push_back('{"ack", 0});
    clock_bit(1'b1, r);
    obs_q.push_back('{"ack", int'(!r)});
    bus_stop();
    tick(4);
    exp_rx(8'h0F);
    drain();

    // Reset in the middle of a read
    tx_push(8'h81); tx_push(8'h42);
    bus_start();
    wr(8'h55, 1);
    clock_bit(1'b1, r);
    snap("rd_bit6_driven", int'(sda_oe), 1);
    snap("mid_rd_tx_count", int'(tx_count), 1);
    rst_n = 1'b0;
    tick(3);
    snap("rstmid_oe", int'(sda_oe), 0);
    snap("rstmid_tx_count", int'(tx_count), 0);
    snap("rstmid_rx_count", int'(rx_count), 0);
    snap("rstmid_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(2);
    bus_stop();
    tick(4);

    for (int i = 0; i < 100 && obs_q.size() > 0; i++) tick();
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected / %0d observed left, need 0", exp_q.size(), obs_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
